divider_4_bit: RTL and testbench

// - Unsigned 4-bit by 4-bit integer divider producing a 4-bit quotient and a 4-bit remainder.
// - Clocked, with a start/done handshake; operands are captured when the request is accepted.
// - Default build is an iterative restoring divider (one quotient bit per cycle).
// - Used as a small arithmetic leaf wherever control logic needs A/B and A%B.
//

---
 rtl/divider_4_bit_if.sv | 22 ++
 rtl/divider_4_bit.sv | 171 +++++++++++++++++
 tb/tb_divider_4_bit.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/divider_4_bit_if.sv
// Request/result bundle for the 4-bit divider.
// Master drives the operands and start; slave returns the result.
interface divider_4_bit_if;
  logic       start;
  logic [3:0] A;
  logic [3:0] B;
  logic [3:0] Q;
  logic [3:0] R;
  logic       busy;
  logic       done;
  logic       dbz;

  modport master (
    output start, A, B,
    input  Q, R, busy, done, dbz
  );

  modport slave (
    input  start, A, B,
    output Q, R, busy, done, dbz
  );
endinterface

// File: rtl/divider_4_bit.sv
// Unsigned 4-bit divider: Q = A / B, R = A % B, with start/done handshake.
// Default: iterative restoring, 1 bit/cycle. DIVIDER_FAST_EN: single-cycle array.
module divider_4_bit (
  input  logic           clk,
  input  logic           rst_n,
  divider_4_bit_if.slave bus
);

  logic [3:0] q_q, q_d;
  logic [3:0] r_q, r_d;
  logic       done_q, done_d;
  logic       dbz_q, dbz_d;

`ifdef DIVIDER_FAST_EN

  logic [3:0] arr_quo;
  logic [3:0] arr_p;
  logic [4:0] arr_t;

  // Four unrolled restoring stages on the live operands
  always_comb begin
    arr_quo = '0;
    arr_p   = '0;
    arr_t   = '0;
    for (int i = 3; i >= 0; i--) begin
      arr_t = {arr_p, bus.A[i]};
      if (arr_t >= {1'b0, bus.B}) begin
        arr_p      = 4'(arr_t - {1'b0, bus.B});
        arr_quo[i] = 1'b1;
      end else begin
        arr_p = arr_t[3:0];
      end
    end
  end

  // Every start loads a fresh result at its own edge
  always_comb begin
    q_d    = q_q;
    r_d    = r_q;
    dbz_d  = dbz_q;
    done_d = 1'b0;
    if (bus.start) begin
      done_d = 1'b1;
      dbz_d  = (bus.B == 4'd0);
      if (bus.B == 4'd0) begin
        q_d = 4'hF;
        r_d = bus.A;
      end else begin
        q_d = arr_quo;
        r_d = arr_p;
      end
    end
  end

  assign bus.busy = 1'b0;

`else

  typedef enum logic {
    S_IDLE,
    S_RUN
  } state_e;

  state_e     state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic [3:0] a_q, a_d;
  logic [3:0] b_q, b_d;
  logic [3:0] p_q, p_d;
  logic [3:0] quo_q, quo_d;

  logic [4:0] trial;
  logic       ge;
  logic [3:0] p_step;
  logic [3:0] quo_step;

  // One restoring step: bring down the next dividend bit, MSB first
  always_comb begin
    trial    = {p_q, a_q[2'd3 - cnt_q]};
    ge       = (trial >= {1'b0, b_q});
    p_step   = ge ? 4'(trial - {1'b0, b_q}) : trial[3:0];
    quo_step = {quo_q[2:0], ge};
  end

  // Accept in idle, iterate 4 steps, publish result on the last one
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    p_d     = p_q;
    quo_d   = quo_q;
    q_d     = q_q;
    r_d     = r_q;
    dbz_d   = dbz_q;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          a_d     = bus.A;
          b_d     = bus.B;
          p_d     = '0;
          quo_d   = '0;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        p_d   = p_step;
        quo_d = quo_step;
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd3) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          dbz_d   = (b_q == 4'd0);
          if (b_q == 4'd0) begin
            q_d = 4'hF;
            r_d = a_q;
          end else begin
            q_d = quo_step;
            r_d = p_step;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Iteration state; reset aborts any division in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      p_q     <= '0;
      quo_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      p_q     <= p_d;
      quo_q   <= quo_d;
    end
  end

  assign bus.busy = (state_q == S_RUN);

`endif

  // Result registers, held until the next completion
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q    <= '0;
      r_q    <= '0;
      done_q <= 1'b0;
      dbz_q  <= 1'b0;
    end else begin
      q_q    <= q_d;
      r_q    <= r_d;
      done_q <= done_d;
      dbz_q  <= dbz_d;
    end
  end

  assign bus.Q    = q_q;
  assign bus.R    = r_q;
  assign bus.done = done_q;
  assign bus.dbz  = dbz_q;

endmodule

// File: tb/tb_divider_4_bit.sv
// Directed and exhaustive checks for divider_4_bit.
// Expected values come from hand tables and A/B, A%B in the bench.
module tb_divider_4_bit;

`ifdef DIVIDER_FAST_EN
  localparam int LAT  = 1;
  localparam int FAST = 1;
`else
  localparam int LAT  = 5;
  localparam int FAST = 0;
`endif

  logic clk;
  logic rst_n;

  divider_4_bit_if bus ();

  divider_4_bit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] q;
    logic [3:0] r;
    logic       dbz;
  } vec_t;

  vec_t vt[12];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Called just after a rising edge; returns edges until done (incl. accept)
  task automatic run_op(input logic [3:0] a, input logic [3:0] b,
                        output int lat);
    bus.A     = a;
    bus.B     = b;
    bus.start = 1'b1;
    lat       = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
      if (lat == 1) begin
        bus.start = 1'b0;
        chk("busy_after_accept", int'(bus.busy), (FAST != 0) ? 0 : 1);
      end
    end while (!bus.done && lat < 10);
  endtask

  initial begin
    int lat;
    int pulses;
    int qe;
    int re;
    int de;
    int ok;

    vt[0]  = '{4'd5,  4'd2, 4'd2,  4'd1, 1'b0};
    vt[1]  = '{4'd15, 4'd3, 4'd5,  4'd0, 1'b0};
    vt[2]  = '{4'd10, 4'd4, 4'd2,  4'd2, 1'b0};
    vt[3]  = '{4'd7,  4'd3, 4'd2,  4'd1, 1'b0};
    vt[4]  = '{4'd9,  4'd5, 4'd1,  4'd4, 1'b0};
    vt[5]  = '{4'd9,  4'd0, 4'd15, 4'd9, 1'b1};
    vt[6]  = '{4'd6,  4'd3, 4'd2,  4'd0, 1'b0};
    vt[7]  = '{4'd0,  4'd7, 4'd0,  4'd0, 1'b0};
    vt[8]  = '{4'd3,  4'd9, 4'd0,  4'd3, 1'b0};
    vt[9]  = '{4'd15, 4'd1, 4'd15, 4'd0, 1'b0};
    vt[10] = '{4'd15, 4'd15, 4'd1, 4'd0, 1'b0};
    vt[11] = '{4'd0,  4'd0, 4'd15, 4'd0, 1'b1};

    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.A     = '0;
    bus.B     = '0;
    #1;
    chk("rst_q",    int'(bus.Q),    0);
    chk("rst_r",    int'(bus.R),    0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_dbz",  int'(bus.dbz),  0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 12; i++) begin
      run_op(vt[i].a, vt[i].b, lat);
      chk($sformatf("v%0d_lat", i), lat, LAT);
      chk($sformatf("v%0d_q", i),   int'(bus.Q),   int'(vt[i].q));
      chk($sformatf("v%0d_r", i),   int'(bus.R),   int'(vt[i].r));
      chk($sformatf("v%0d_dbz", i), int'(bus.dbz), int'(vt[i].dbz));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_done_pulse", i), int'(bus.done), 0);
    end

    // start held while busy must not queue a second division
    bus.A     = 4'd15;
    bus.B     = 4'd3;
    bus.start = 1'b1;
    pulses    = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      if (bus.done) pulses++;
      if (c == 0) begin
        bus.A = 4'd8;
        bus.B = 4'd2;
      end
      if (c == 2) bus.start = 1'b0;
    end
    chk("ign_pulses", pulses, (FAST != 0) ? 3 : 1);
    chk("ign_q", int'(bus.Q), (FAST != 0) ? 4 : 5);
    chk("ign_r", int'(bus.R), 0);

    // asynchronous reset in the middle of a division
    bus.A     = 4'd5;
    bus.B     = 4'd2;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_q",    int'(bus.Q),    0);
    chk("mid_rst_r",    int'(bus.R),    0);
    chk("mid_rst_busy", int'(bus.busy), 0);
    chk("mid_rst_done", int'(bus.done), 0);
    chk("mid_rst_dbz",  int'(bus.dbz),  0);
    @(negedge clk);
    rst_n  = 1'b1;
    pulses = 0;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (bus.done) pulses++;
    end
    chk("mid_rst_no_done", pulses, 0);

    // all pairs, next start issued in each done cycle
    bus.start = 1'b1;
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        bus.A = 4'(a);
        bus.B = 4'(b);
        lat   = 0;
        do begin
          @(posedge clk);
          #1;
          lat++;
        end while (!bus.done && lat < 10);
        if (b == 0) begin
          qe = 15;
          re = a;
          de = 1;
        end else begin
          qe = a / b;
          re = a % b;
          de = 0;
        end
        ok = (int'(bus.Q) == qe) && (int'(bus.R) == re) &&
             (int'(bus.dbz) == de) && (lat == LAT);
        checks++;
        if (ok == 0) begin
          errors++;
          $display("FAIL exh_%0d_%0d: got q=%0d r=%0d dbz=%0d lat=%0d expected q=%0d r=%0d dbz=%0d lat=%0d",
                   a, b, bus.Q, bus.R, bus.dbz, lat, qe, re, de, LAT);
        end
        if (b != 0) begin
          chk($sformatf("exh_%0d_%0d_ident", a, b),
              int'(bus.Q) * b + int'(bus.R), a);
        end
      end
    end
    bus.start = 1'b0;
    @(posedge clk);
    #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
